// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-back arbiter: requester and
// round-robin state encodings plus the default-width write request.
package regfile_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_MEM = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// wb_fifo: small power-of-two FIFO with wrap-bit pointers; exposes every slot
// and a per-slot occupancy vector so the owner can search queued entries.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [W-1:0]            din_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [W-1:0]            head_o,
    output logic [DEPTH-1:0][W-1:0] entries_o,
    output logic [DEPTH-1:0]        valid_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PTR_W-1:0]        count_s;
    logic                    pop_en_s, push_en_s;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_en_s  = pop_i && !empty_o;
    // A full buffer may still take a write when the head leaves on the same edge.
    assign push_en_s = push_i && (!full_o || pop_en_s);
    assign count_s   = wptr_q - rptr_q;
    assign head_o    = mem_q[rptr_q[AW-1:0]];
    assign entries_o = mem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
            mem_q  <= {(DEPTH*W){1'b0}};
        end else begin
            if (push_en_s) begin
                mem_q[wptr_q[AW-1:0]] <= din_i;
                wptr_q                <= wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_en_s) begin
                rptr_q <= rptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        valid_o = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = ({1'b0, AW'(i) - rptr_q[AW-1:0]} < count_s);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-back arbiter: ALU and load results queue per requester and
// issue one write per cycle. Define REGFILE_ARB_PENDING_EN for pend1/pend2 lookup.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              pend1,
    output logic              pend2
);

    localparam int W = ADDR_W + DATA_W;

    logic                    alu_push_s, mem_push_s, alu_pop_s, mem_pop_s;
    logic                    alu_full_s, mem_full_s, alu_empty_s, mem_empty_s;
    logic [W-1:0]            alu_head_s, mem_head_s;
    logic [DEPTH-1:0][W-1:0] alu_ents_s, mem_ents_s;
    logic [DEPTH-1:0]        alu_vld_s, mem_vld_s;
    arb_state_e              state_q, state_d;
    req_e                    gnt_sel_s;
    logic                    gnt_vld_s;
    logic [ADDR_W-1:0]       gnt_addr_s, rf_waddr_q;
    logic [DATA_W-1:0]       gnt_data_s, rf_wdata_q;
    logic                    rf_we_q;
    logic                    unused_ents_s;

    assign alu_ready  = !reset && !alu_full_s;
    assign mem_ready  = !reset && !mem_full_s;
    // Writes to register 0 are accepted but never stored.
    assign alu_push_s = alu_valid && alu_ready && (alu_addr != {ADDR_W{1'b0}});
    assign mem_push_s = mem_valid && mem_ready && (mem_addr != {ADDR_W{1'b0}});
    assign alu_pop_s  = gnt_vld_s && (gnt_sel_s == REQ_ALU);
    assign mem_pop_s  = gnt_vld_s && (gnt_sel_s == REQ_MEM);

    wb_fifo #(.DEPTH(DEPTH), .W(W)) u_alu_fifo (
        .clk(clk), .reset(reset), .push_i(alu_push_s), .din_i({alu_addr, alu_data}),
        .pop_i(alu_pop_s), .full_o(alu_full_s), .empty_o(alu_empty_s),
        .head_o(alu_head_s), .entries_o(alu_ents_s), .valid_o(alu_vld_s)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(W)) u_mem_fifo (
        .clk(clk), .reset(reset), .push_i(mem_push_s), .din_i({mem_addr, mem_data}),
        .pop_i(mem_pop_s), .full_o(mem_full_s), .empty_o(mem_empty_s),
        .head_o(mem_head_s), .entries_o(mem_ents_s), .valid_o(mem_vld_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LAST_MEM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gnt_vld_s) begin
            case (gnt_sel_s)
                REQ_ALU: state_d = LAST_ALU;
                REQ_MEM: state_d = LAST_MEM;
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Grant: same-address collision favours the load so its value lands last-but-one.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_sel_s = REQ_ALU;
        if (!alu_empty_s && !mem_empty_s) begin
            gnt_vld_s = 1'b1;
            if ((alu_head_s[W-1:DATA_W] == mem_head_s[W-1:DATA_W]) &&
                (mem_head_s[W-1:DATA_W] != {ADDR_W{1'b0}})) begin
                gnt_sel_s = REQ_MEM;
            end else if (state_q == LAST_MEM) begin
                gnt_sel_s = REQ_ALU;
            end else begin
                gnt_sel_s = REQ_MEM;
            end
        end else if (!alu_empty_s) begin
            gnt_vld_s = 1'b1;
            gnt_sel_s = REQ_ALU;
        end else if (!mem_empty_s) begin
            gnt_vld_s = 1'b1;
            gnt_sel_s = REQ_MEM;
        end else begin
            gnt_vld_s = 1'b0;
        end
        if (gnt_sel_s == REQ_MEM) begin
            gnt_addr_s = mem_head_s[W-1:DATA_W];
            gnt_data_s = mem_head_s[DATA_W-1:0];
        end else begin
            gnt_addr_s = alu_head_s[W-1:DATA_W];
            gnt_data_s = alu_head_s[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {ADDR_W{1'b0}};
            rf_wdata_q <= {DATA_W{1'b0}};
        end else begin
            rf_we_q <= gnt_vld_s;
            if (gnt_vld_s) begin
                rf_waddr_q <= gnt_addr_s;
                rf_wdata_q <= gnt_data_s;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Queued data fields are never searched.
    assign unused_ents_s = ^{alu_ents_s, mem_ents_s};

`ifdef REGFILE_ARB_PENDING_EN
    logic pend1_s, pend2_s;

    always_comb begin
        pend1_s = rf_we_q && (rf_waddr_q == rd_addr1);
        pend2_s = rf_we_q && (rf_waddr_q == rd_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            pend1_s = pend1_s | (alu_vld_s[i] && (alu_ents_s[i][W-1:DATA_W] == rd_addr1))
                              | (mem_vld_s[i] && (mem_ents_s[i][W-1:DATA_W] == rd_addr1));
            pend2_s = pend2_s | (alu_vld_s[i] && (alu_ents_s[i][W-1:DATA_W] == rd_addr2))
                              | (mem_vld_s[i] && (mem_ents_s[i][W-1:DATA_W] == rd_addr2));
        end
        pend1_s = pend1_s && (rd_addr1 != {ADDR_W{1'b0}});
        pend2_s = pend2_s && (rd_addr2 != {ADDR_W{1'b0}});
    end

    assign pend1 = pend1_s;
    assign pend2 = pend2_s;
`else
    logic unused_pend_s;

    assign unused_pend_s = ^{rd_addr1, rd_addr2, alu_vld_s, mem_vld_s};
    assign pend1         = 1'b0;
    assign pend2         = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes go into a scoreboard
// queue as stimulus is driven and are popped whenever rf_we is seen.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

`ifdef REGFILE_ARB_PENDING_EN
    localparam logic PEND_EN = 1'b1;
`else
    localparam logic PEND_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr, rd_addr1, rd_addr2;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rf_we, pend1, pend2;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int          checks = 0;
    int          errors = 0;
    wr_req_t     sb[$];

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend1(pend1), .pend2(pend2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wr_req_t mk(input logic [4:0] a, input logic [31:0] d);
        wr_req_t r;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then score any write the DUT issued.
    task automatic step();
        wr_req_t e;
        @(posedge clk);
        #1;
        if (rf_we === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_write observed addr=%0d data=%0h expected no write",
                       rf_waddr, rf_wdata);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_addr", 64'(rf_waddr), 64'(e.addr));
                chk("sb_data", 64'(rf_wdata), 64'(e.data));
            end
        end
    endtask

    initial begin
        int  ai, mi;
        logic a_fire, m_fire;

        reset = 1'b1;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd0;
        step();
        step();
        chk("rst_we",    64'(rf_we),     64'd0);
        chk("rst_waddr", 64'(rf_waddr),  64'd0);
        chk("rst_wdata", 64'(rf_wdata),  64'd0);
        chk("rst_aready", 64'(alu_ready), 64'd0);
        chk("rst_mready", 64'(mem_ready), 64'd0);
        chk("rst_pend1", 64'(pend1),     64'd0);
        chk("rst_pend2", 64'(pend2),     64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_aready", 64'(alu_ready), 64'd1);
        chk("post_rst_mready", 64'(mem_ready), 64'd1);

        // Single write with pending tracking.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        sb.push_back(mk(5'd5, 32'hDEADBEEF));
        chk("t1_pend_before", 64'(pend1), 64'd0);
        step();
        alu_valid = 1'b0;
        chk("t1_we_e0",   64'(rf_we), 64'd0);
        chk("t1_pend_e0", 64'(pend1), 64'(PEND_EN));
        step();
        chk("t1_we_e1",   64'(rf_we), 64'd1);
        chk("t1_pend_e1", 64'(pend1), 64'(PEND_EN));
        step();
        chk("t1_we_e2",    64'(rf_we),    64'd0);
        chk("t1_pend_e2",  64'(pend1),    64'd0);
        step();
        chk("t1_hold_addr", 64'(rf_waddr), 64'd5);
        chk("t1_hold_data", 64'(rf_wdata), 64'hDEADBEEF);

        // Reset pulse so contention starts from the post-reset arbiter state.
        reset = 1'b1;
        #1;
        chk("pulse_aready", 64'(alu_ready), 64'd0);
        step();
        reset = 1'b0;
        step();

        // Contention, then a back-to-back repeat while the first pair drains.
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
        sb.push_back(mk(5'd3, 32'h11));
        sb.push_back(mk(5'd4, 32'h22));
        sb.push_back(mk(5'd3, 32'h33));
        sb.push_back(mk(5'd4, 32'h44));
        step();
        alu_data = 32'h33; mem_data = 32'h44;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("t2_drained", 64'(sb.size()), 64'd0);

        // Same address on both sides: MEM goes first although ALU holds the turn.
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hB;
        rd_addr2 = 5'd7;
        sb.push_back(mk(5'd7, 32'hB));
        sb.push_back(mk(5'd7, 32'hA));
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("t3_pend2", 64'(pend2), 64'(PEND_EN));
        for (int k = 0; k < 3; k++) step();
        chk("t3_drained", 64'(sb.size()), 64'd0);

        // Register 0: accepted, never stored, never written, never pending.
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF;
        chk("t4_ready_pre", 64'(alu_ready), 64'd1);
        step();
        step();
        alu_valid = 1'b0;
        chk("t4_ready_post", 64'(alu_ready), 64'd1);
        chk("t4_pend1",      64'(pend1),     64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_no_we", 64'(rf_we), 64'd0);
        end

        // Reset with two entries queued and one write in flight.
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC0;
        mem_valid = 1'b1; mem_addr = 5'd13; mem_data = 32'hD0;
        rd_addr1 = 5'd12; rd_addr2 = 5'd13;
        sb.push_back(mk(5'd13, 32'hD0));
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("t6_pend1_q", 64'(pend1), 64'(PEND_EN));
        chk("t6_pend2_q", 64'(pend2), 64'(PEND_EN));
        step();
        chk("t6_we_inflight", 64'(rf_we), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_we_cleared", 64'(rf_we),     64'd0);
        chk("t6_aready_rst", 64'(alu_ready), 64'd0);
        chk("t6_mready_rst", 64'(mem_ready), 64'd0);
        chk("t6_pend1_rst",  64'(pend1),     64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t6_aready_rel", 64'(alu_ready), 64'd1);
        chk("t6_mready_rel", 64'(mem_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_no_we", 64'(rf_we), 64'd0);
        end
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: three ALU writes against a continuously valid MEM stream.
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        sb.push_back(mk(5'd8,  32'h100));
        sb.push_back(mk(5'd16, 32'h200));
        sb.push_back(mk(5'd9,  32'h101));
        sb.push_back(mk(5'd17, 32'h201));
        sb.push_back(mk(5'd10, 32'h102));
        sb.push_back(mk(5'd18, 32'h202));
        sb.push_back(mk(5'd19, 32'h203));
        ai = 0;
        mi = 0;
        for (int k = 0; k < 20; k++) begin
            alu_valid = (ai < 3);
            alu_addr  = 5'(8 + ai);
            alu_data  = 32'(32'h100 + ai);
            mem_valid = (mi < 4);
            mem_addr  = 5'(16 + mi);
            mem_data  = 32'(32'h200 + mi);
            #1;
            if (k == 2) chk("t5_mem_full", 64'(mem_ready), 64'd0);
            if (k == 3) chk("t5_alu_full", 64'(alu_ready), 64'd0);
            a_fire = alu_valid && alu_ready;
            m_fire = mem_valid && mem_ready;
            step();
            if (a_fire) ai++;
            if (m_fire) mi++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("t5_alu_accepted", 64'(ai), 64'd3);
        chk("t5_mem_accepted", 64'(mi), 64'd4);
        chk("t5_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
